mult_div_unit: RTL and testbench

//  Multicycle signed MULT/DIV unit for the multicycle CPU; computes a 64-bit product or quotient/remainder over 33 cycles.

---
 rtl/mult_div_pkg.sv | 21 ++
 rtl/restoring_div_step.sv | 29 ++
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared types and constants for the signed multicycle MULT/DIV unit.
// The divide-by-zero trap is controlled by the DIV_ZERO_EXC_EN macro (see mult_div_unit).
package mult_div_pkg;

  localparam int unsigned MD_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StDiv,
    StFix
  } md_state_e;

  function automatic md_state_e op_to_state(input logic op);
    return (op == OP_DIV) ? StDiv : StMult;
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One iteration of unsigned restoring division: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module restoring_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic             unused_msbs;

  always_comb begin
    rem_sh = {rem_i, quot_i[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, divisor_i};
    fits   = ~diff[WIDTH+1];
    // The remainder stays below the divisor, so the top bits carry no information.
    rem_o  = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quot_o = {quot_i[WIDTH-2:0], fits};
  end

  assign unused_msbs = ^{diff[WIDTH], rem_sh[WIDTH]};

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit: sign-magnitude conversion, 32 shift-add or restoring
// iterations, then a sign fix-up into HI/LO. Define DIV_ZERO_EXC_EN to trap DIV by zero.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  // Multiplicand magnitude for MULT, divisor magnitude for DIV.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // MULT: {partial product, remaining multiplier}; DIV: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH-1:0]   div_rem, div_quot;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               zero_trap;
  logic               last_iter;

`ifdef DIV_ZERO_EXC_EN
  assign zero_trap = (op == OP_DIV) && (b_in == '0);
`else
  assign zero_trap = 1'b0;
`endif

  // A WIDTH-bit unsigned magnitude is exact even for the most negative operand.
  assign mag_a     = a_in[WIDTH-1] ? -a_in : a_in;
  assign mag_b     = b_in[WIDTH-1] ? -b_in : b_in;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  restoring_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i    (work_q[2*WIDTH-1:WIDTH]),
    .quot_i   (work_q[WIDTH-1:0]),
    .divisor_i(opnd_q),
    .rem_o    (div_rem),
    .quot_o   (div_quot)
  );

  always_comb begin
    mult_sum = work_q[0] ? ({1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q})
                         : {1'b0, work_q[2*WIDTH-1:WIDTH]};
    prod_fix = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
    quot_fix = (sign_a_q ^ sign_b_q) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = sign_a_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    opnd_d     = opnd_q;
    work_d     = work_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && zero_trap) begin
          div_zero_d = 1'b1;
        end else if (start) begin
          state_d  = op_to_state(op);
          cnt_d    = '0;
          op_d     = op;
          sign_a_d = a_in[WIDTH-1];
          sign_b_d = b_in[WIDTH-1];
          if (op == OP_DIV) begin
            opnd_d = mag_b;
            work_d = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            work_d = {{WIDTH{1'b0}}, mag_b};
          end
        end
      end
      StMult: begin
        work_d = {mult_sum, work_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) state_d = StFix;
      end
      StDiv: begin
        work_d = {div_rem, div_quot};
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_iter) state_d = StFix;
      end
      StFix: begin
        if (op_q == OP_DIV) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      opnd_q     <= '0;
      work_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      opnd_q     <= opnd_d;
      work_q     <= work_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written multi-cycle
// sequences and randomized operations against a plain-arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, op;
  logic [31:0] a_in, b_in, hi_out, lo_out;
  logic        busy, done, div_zero;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] cur;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .hi_out  (hi_out),
    .lo_out  (lo_out),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // {HI,LO} the specification requires; prev is what HI/LO held before the op.
  function automatic logic [63:0] model(input logic o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == OP_MULT) return 64'(sa * sb);
    if (b == 32'd0) begin
`ifdef DIV_ZERO_EXC_EN
      return prev;
`else
      return {a, (sa < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF};
`endif
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic is_trap(input logic o, input logic [31:0] b);
`ifdef DIV_ZERO_EXC_EN
    return (o == OP_DIV) && (b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output logic dz,
                        output logic dz2, output int nbusy);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
    dz = div_zero; dz2 = 1'b0; lat = -1; nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == 1) dz2 = div_zero;
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
    end
    res = {hi_out, lo_out};
  endtask

  task automatic check_op(input string name, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
    logic [63:0] res;
    int          lat, nbusy;
    logic        dz, dz2, trap;
    trap = is_trap(o, b);
    run_op(o, a, b, res, lat, dz, dz2, nbusy);
    check({name, " hilo"}, res, exp);
    check({name, " latency"}, 64'(lat), trap ? 64'(-1) : 64'(33));
    check({name, " busy cycles"}, 64'(nbusy), trap ? 64'(0) : 64'(33));
    check({name, " div_zero"}, 64'(dz), 64'(trap));
    check({name, " div_zero one cycle"}, 64'(dz2), 64'(0));
    cur = exp;
  endtask

  initial begin
    logic [63:0] exp;
    logic [31:0] ra, rb;
    logic        ro, seen;
    int          lat;

    vecs[0] = '{OP_MULT, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2] = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[4] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[6] = '{OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[7] = '{OP_DIV,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
    vecs[8] = '{OP_DIV,  32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E};
    vecs[9] = '{OP_MULT, 32'd0,         32'h1234_5678, 32'h0000_0000, 32'h0000_0000};

    reset = 1'b1; start = 1'b0; op = OP_MULT; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset hilo", {hi_out, lo_out}, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    cur = '0;

    for (int i = 0; i < 10; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
               {vecs[i].hi, vecs[i].lo});
    end

    // Divide by zero: trapped or run to completion depending on configuration.
`ifdef DIV_ZERO_EXC_EN
    check_op("div5by0", OP_DIV, 32'd5, 32'd0, cur);
`else
    check_op("div5by0", OP_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
`endif

    // A second start while busy must be ignored.
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a_in = 32'h8000_0000; b_in = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      if (k == 10) begin
        start = 1'b1; op = OP_MULT; a_in = 32'd3; b_in = 32'd4;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check("busy start latency", 64'(lat), 64'd33);
    check("busy start hilo", {hi_out, lo_out}, {32'h0, 32'h8000_0000});
    @(posedge clk); #1;
    check("busy start not queued", 64'(busy), 64'd0);
    cur = {32'h0, 32'h8000_0000};

    // Reset in the middle of a MULT aborts it immediately.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a_in = 32'd12345; b_in = 32'd678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset hilo", {hi_out, lo_out}, 64'd0);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("midreset no done", 64'(seen), 64'd0);
    cur = '0;
    check_op("mult3x4", OP_MULT, 32'd3, 32'd4, 64'd12);

    for (int i = 0; i < 30; i++) begin
      ro = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      exp = model(ro, ra, rb, cur);
      check_op($sformatf("rand%0d op=%0d a=%h b=%h", i, ro, ra, rb), ro, ra, rb, exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
